// File: rtl/condlogic.sv
// Conditional-execution stage: holds NZCV and gates the decoder's write requests
// by the instruction's condition field.
module condlogic (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    input  logic       pcs_i,
    input  logic       next_pc_i,
    input  logic       reg_w_i,
    input  logic       mem_w_i,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic [3:0] flags_o
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_delayed_q, cond_ex_delayed_d;
    logic       cond_ex;
    logic [1:0] flag_write;
    logic       n_flag, z_flag, c_flag, v_flag;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond_i)
            4'b0000: cond_ex = z_flag;
            4'b0001: cond_ex = ~z_flag;
            4'b0010: cond_ex = c_flag;
            4'b0011: cond_ex = ~c_flag;
            4'b0100: cond_ex = n_flag;
            4'b0101: cond_ex = ~n_flag;
            4'b0110: cond_ex = v_flag;
            4'b0111: cond_ex = ~v_flag;
            4'b1000: cond_ex = c_flag & ~z_flag;
            4'b1001: cond_ex = ~c_flag | z_flag;
            4'b1010: cond_ex = (n_flag == v_flag);
            4'b1011: cond_ex = (n_flag != v_flag);
            4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_ex = z_flag | (n_flag != v_flag);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flag writes use the undelayed condition so a flag-setting conditional
    // instruction is gated by the flags it was decoded against.
    assign flag_write = flag_w_i & {2{cond_ex}};

    always_comb begin
        flags_d = flags_q;
        if (flag_write[1]) flags_d[3:2] = alu_flags_i[3:2];
        if (flag_write[0]) flags_d[1:0] = alu_flags_i[1:0];
        cond_ex_delayed_d = cond_ex;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flags_q           <= 4'b0000;
            cond_ex_delayed_q <= 1'b0;
        end else begin
            flags_q           <= flags_d;
            cond_ex_delayed_q <= cond_ex_delayed_d;
        end
    end

    assign pc_write_o  = (pcs_i & cond_ex_delayed_q) | next_pc_i;
    assign reg_write_o = reg_w_i & cond_ex_delayed_q;
    assign mem_write_o = mem_w_i & cond_ex_delayed_q;
    assign flags_o     = flags_q;

endmodule

// File: tb/tb_condlogic.sv
// Directed bench for condlogic with a behavioural NZCV/condition model and literal pins.
module tb_condlogic;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [3:0] cond_i, alu_flags_i;
    logic [1:0] flag_w_i;
    logic       pcs_i, next_pc_i, reg_w_i, mem_w_i;
    logic       pc_write_o, reg_write_o, mem_write_o;
    logic [3:0] flags_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: architectural flags and the condition result of the previous cycle.
    logic [3:0] m_flags = 4'b0000;
    logic       m_prev_pass = 1'b0;

    condlogic dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cond_i      (cond_i),
        .alu_flags_i (alu_flags_i),
        .flag_w_i    (flag_w_i),
        .pcs_i       (pcs_i),
        .next_pc_i   (next_pc_i),
        .reg_w_i     (reg_w_i),
        .mem_w_i     (mem_w_i),
        .pc_write_o  (pc_write_o),
        .reg_write_o (reg_write_o),
        .mem_write_o (mem_write_o),
        .flags_o     (flags_o)
    );

    always #5 clk_i = ~clk_i;

    // ARM definition: even codes test a base predicate, odd codes its negation;
    // 1111 never executes.
    function automatic logic model_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n ^ v) == 1'b0;
            3'd6: base = ((n ^ v) == 1'b0) && !z;
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return base ^ c[0];
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs mid-cycle, then compare all outputs against the model.
    task automatic drive(input logic rst, input logic [3:0] c, input logic [3:0] alu,
                         input logic [1:0] fw, input logic pcs, input logic npc,
                         input logic rw, input logic mw);
        reset_i = rst; cond_i = c; alu_flags_i = alu; flag_w_i = fw;
        pcs_i = pcs; next_pc_i = npc; reg_w_i = rw; mem_w_i = mw;
        #3;
        chk("model_pcwrite",  {3'b0, pc_write_o},  {3'b0, (pcs & m_prev_pass) | npc});
        chk("model_regwrite", {3'b0, reg_write_o}, {3'b0, rw & m_prev_pass});
        chk("model_memwrite", {3'b0, mem_write_o}, {3'b0, mw & m_prev_pass});
        chk("model_flags",    flags_o,             m_flags);
    endtask

    task automatic tick();
        logic pass;
        @(posedge clk_i);
        pass = model_pass(cond_i, m_flags);
        if (reset_i) begin
            m_flags     = 4'b0000;
            m_prev_pass = 1'b0;
        end else begin
            if (pass && flag_w_i[1]) m_flags[3:2] = alu_flags_i[3:2];
            if (pass && flag_w_i[0]) m_flags[1:0] = alu_flags_i[1:0];
            m_prev_pass = pass;
        end
        #1;
    endtask

    initial begin
        reset_i = 1'b1; cond_i = 4'hE; alu_flags_i = 4'hF; flag_w_i = 2'b11;
        pcs_i = 1'b0; next_pc_i = 1'b0; reg_w_i = 1'b1; mem_w_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Reset held with flag writes and write requests pending.
        drive(1, 4'hE, 4'hF, 2'b11, 0, 0, 1, 1);
        chk("rst_regwrite", {3'b0, reg_write_o}, 4'd0);
        chk("rst_memwrite", {3'b0, mem_write_o}, 4'd0);
        chk("rst_pcwrite0", {3'b0, pc_write_o}, 4'd0);
        tick();
        drive(1, 4'hE, 4'hF, 2'b11, 0, 1, 1, 1);
        chk("rst_pcwrite1", {3'b0, pc_write_o}, 4'd1);
        tick();
        chk("rst_flags", flags_o, 4'b0000);

        // AL loads flags, then EQ passes.
        drive(0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
        tick();
        chk("al_flags", flags_o, 4'b0100);
        drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0);
        tick();
        drive(0, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0);
        chk("eq_regwrite", {3'b0, reg_write_o}, 4'd1);
        tick();

        // Failing NE blocks flag write and the following memory write.
        drive(0, 4'h1, 4'b1011, 2'b11, 0, 0, 0, 0);
        tick();
        chk("ne_flags_held", flags_o, 4'b0100);
        drive(0, 4'h1, 4'h0, 2'b00, 0, 0, 0, 1);
        chk("ne_memwrite", {3'b0, mem_write_o}, 4'd0);
        tick();

        // Partial group writes.
        drive(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        tick();
        drive(0, 4'hE, 4'hF, 2'b10, 0, 0, 0, 0);
        tick();
        chk("part_nz", flags_o, 4'b1100);
        drive(0, 4'hE, 4'b0011, 2'b01, 0, 0, 0, 0);
        tick();
        chk("part_cv", flags_o, 4'b1111);

        // N=1, V=0: GE fails, LT passes, branch under LT.
        drive(0, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
        tick();
        drive(0, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0);
        tick();
        drive(0, 4'hB, 4'h0, 2'b00, 0, 0, 1, 0);
        chk("ge_fails", {3'b0, reg_write_o}, 4'd0);
        tick();
        drive(0, 4'hB, 4'h0, 2'b00, 1, 0, 1, 0);
        chk("lt_passes", {3'b0, reg_write_o}, 4'd1);
        tick();
        drive(0, 4'hE, 4'h0, 2'b00, 1, 0, 0, 0);
        chk("lt_branch", {3'b0, pc_write_o}, 4'd1);
        tick();

        // Z=1: GT fails, LE passes.
        drive(0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
        tick();
        drive(0, 4'hC, 4'h0, 2'b00, 0, 0, 0, 0);
        tick();
        drive(0, 4'hD, 4'h0, 2'b00, 0, 0, 1, 0);
        chk("gt_fails", {3'b0, reg_write_o}, 4'd0);
        tick();
        drive(0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0);
        chk("le_passes", {3'b0, reg_write_o}, 4'd1);
        tick();

        // ADDEQS-style: EQ tests old Z=1, so the new flags load.
        drive(0, 4'h0, 4'b0010, 2'b11, 0, 0, 0, 0);
        tick();
        chk("eqs_load", flags_o, 4'b0010);
        drive(0, 4'h0, 4'b0100, 2'b11, 0, 0, 0, 0);
        tick();
        chk("eqs_block", flags_o, 4'b0010);

        // Unsupported 1111 never executes.
        drive(0, 4'hF, 4'hF, 2'b11, 1, 0, 0, 0);
        tick();
        drive(0, 4'hF, 4'h0, 2'b00, 1, 0, 0, 0);
        chk("nv_pcwrite", {3'b0, pc_write_o}, 4'd0);
        tick();
        chk("nv_flags", flags_o, 4'b0010);

        // NextPC bypasses a failing EQ (Z=0).
        drive(0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0);
        chk("nextpc_bypass", {3'b0, pc_write_o}, 4'd1);
        tick();

        // Reset mid-instruction discards the delayed condition.
        drive(0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0);
        tick();
        drive(1, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0);
        chk("mid_rst_before", {3'b0, reg_write_o}, 4'd1);
        tick();
        drive(0, 4'hE, 4'h0, 2'b00, 0, 0, 1, 0);
        chk("mid_rst_after", {3'b0, reg_write_o}, 4'd0);
        tick();

        // Random sweep against the model.
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/condlogic.md
# condlogic

Conditional-execution stage of the multicycle ARM controller, directly downstream of the instruction decoder. It holds the NZCV status flags and evaluates the instruction's 4-bit condition field against them. It gates the decoder's raw write requests (PCS, RegW, MemW, FlagW) into the architectural enables (PCWrite, RegWrite, MemWrite, flag-register enables) that drive the datapath. NextPC from the main FSM passes through ungated.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- Cond  input  4  instruction condition field, Instr[31:28]
- ALUFlags  input  4  ALU result flags {N,Z,C,V} of the current cycle
- FlagW  input  2  decoder flag-write request; [1] = N,Z group; [0] = C,V group
- PCS  input  1  decoder request to write PC (branch or Rd=R15 write)
- NextPC  input  1  FSM request for sequential PC update (fetch); unconditional
- RegW  input  1  decoder register-file write request
- MemW  input  1  decoder memory write request
- PCWrite  output  1  PC register enable
- RegWrite  output  1  register-file write enable
- MemWrite  output  1  data-memory write enable
- Flags  output  4  current architectural {N,Z,C,V}, for debug and bench observation

## Operation
- State: Flags[3:0] register; CondExDelayed 1-bit register.
- CondEx is combinational from Cond and the registered Flags (N=Flags[3], Z=[2], C=[1], V=[0]):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 0. Unsupported; the instruction is never executed. No X may be produced.
- FlagWrite[1:0] = FlagW & {2{CondEx}}.
  - FlagWrite[1] loads Flags[3:2] from ALUFlags[3:2].
  - FlagWrite[0] loads Flags[1:0] from ALUFlags[1:0].
  - The two groups update independently.
- CondExDelayed <= CondEx every cycle.
- PCWrite = (PCS & CondExDelayed) | NextPC.
- RegWrite = RegW & CondExDelayed.
- MemWrite = MemW & CondExDelayed.

## Timing
- Reset: Flags = 4'b0000 and CondExDelayed = 0 after the first clock edge with reset high. Outputs are then:
  - PCWrite = NextPC
  - RegWrite = 0
  - MemWrite = 0
  - Flags = 0
- Reset has priority over any simultaneous FlagWrite. Reset asserted mid-instruction discards pending condition state; no write enable other than NextPC is asserted in the following cycle.
- Flag update latency: ALUFlags sampled at edge t are visible on Flags and in CondEx at t+1.
- The condition is evaluated against Flags as they stand in the cycle before the gated write, i.e. the decode cycle's flags. CondExDelayed covers the one-cycle skew between the Decode state and the Execute/Memory/Writeback states in the main FSM.
- An instruction that both sets flags and is conditional (e.g. ADDEQS) tests the old flags. FlagWrite uses the undelayed CondEx, computed from pre-update Flags, so the new flags are never self-gating.
- FlagW, PCS, RegW and MemW are level requests. Each output is purely combinational from inputs and registers in the same cycle; no handshake.
- NextPC asserts PCWrite in the same cycle regardless of Cond, Flags or reset state.

## Test plan
- Reset: hold reset 2 cycles with FlagW=11, ALUFlags=1111 -> Flags=0000; RegWrite=0 and MemWrite=0 with RegW=MemW=1; PCWrite=1 only when NextPC=1.
- AL and flag load: Cond=1110, FlagW=11, ALUFlags=0100 for one cycle -> next cycle Flags=0100. Then Cond=0000 (EQ), RegW=1 for 2 cycles -> RegWrite=1 in the second cycle.
- Failed condition blocks flag write: Flags=0100, Cond=0001 (NE), FlagW=11, ALUFlags=1011 -> Flags stays 0100. With MemW=1 next cycle, MemWrite=0.
- Partial write: Flags=0000, Cond=1110, FlagW=10, ALUFlags=1111 -> Flags=1100. Then FlagW=01, ALUFlags=0011 -> Flags=1111.
- Signed compares: Flags N=1,V=0 -> GE gives CondEx=0 and LT gives 1. Flags Z=1 -> GT gives 0 and LE gives 1. Branch with PCS=1 under LT -> PCWrite=1 one cycle later. Cond=1111 with PCS=1, NextPC=0 -> PCWrite=0.
- NextPC bypass and mid-op reset: Cond=0000 with Z=0, NextPC=1 -> PCWrite=1. Assert reset while RegW=1 and CondExDelayed=1 -> RegWrite=0 from the cycle after the reset edge.
